// File: rtl/i_fab_filter.sv
// Fabric input-capture primitive: WIDTH independent channels presented through
// bypass, register, two-flop synchroniser or synchroniser+glitch-filter capture.

module i_fab_filter_lane #(
    parameter int   MODE_ID = 3,
    parameter int   FC      = 4,
    parameter logic INIT    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(FC + 1);

    generate
        if (MODE_ID == 0) begin : g_bypass
            assign dout = din;
            assign rise = 1'b0;
            assign fall = 1'b0;
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst_n, en};
        end else begin : g_cap
            logic          s1_q, s1_d, s2_q, s2_d, o_q, o_d;
            logic          rise_q, rise_d, fall_q, fall_d;
            logic [CW-1:0] cnt_q, cnt_d;

            always_comb begin
                s1_d   = s1_q;
                s2_d   = s2_q;
                o_d    = o_q;
                cnt_d  = cnt_q;
                rise_d = 1'b0;
                fall_d = 1'b0;
                if (en) begin
                    s1_d = din;
                    s2_d = s1_q;
                    if (MODE_ID == 1) begin
                        o_d = din;
                    end else if (MODE_ID == 2) begin
                        // o_q tracks s2 exactly, one stage behind s1
                        o_d = s1_q;
                    end else begin
                        if (s2_q == o_q) begin
                            cnt_d = '0;
                        end else if (cnt_q == CW'(FC - 1)) begin
                            o_d   = s2_q;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    rise_d = ~o_q & o_d;
                    fall_d = o_q & ~o_d;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_q   <= INIT;
                    s2_q   <= INIT;
                    o_q    <= INIT;
                    cnt_q  <= '0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    s1_q   <= s1_d;
                    s2_q   <= s2_d;
                    o_q    <= o_d;
                    cnt_q  <= cnt_d;
                    rise_q <= rise_d;
                    fall_q <= fall_d;
                end
            end

            assign dout = o_q;
            assign rise = rise_q;
            assign fall = fall_q;
        end
    endgenerate
endmodule

module i_fab_filter #(
    parameter int               WIDTH         = 1,
    parameter string            MODE          = "FILTER",
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] INIT_VALUE    = {WIDTH{1'b0}}
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL
);
    localparam int MODE_ID = (MODE == "BYPASS") ? 0 :
                             (MODE == "REG")    ? 1 :
                             (MODE == "SYNC")   ? 2 :
                             (MODE == "FILTER") ? 3 : -1;

    generate
        if (MODE_ID < 0) begin : g_bad_mode
            $fatal(1, "i_fab_filter: illegal MODE %s", MODE);
        end
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $fatal(1, "i_fab_filter: illegal WIDTH %0d", WIDTH);
        end
        if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_fc
            $fatal(1, "i_fab_filter: illegal FILTER_CYCLES %0d", FILTER_CYCLES);
        end

        for (genvar n = 0; n < WIDTH; n++) begin : g_lane
            i_fab_filter_lane #(
                .MODE_ID (MODE_ID),
                .FC      (FILTER_CYCLES),
                .INIT    (INIT_VALUE[n])
            ) u_lane (
                .clk   (C),
                .rst_n (R),
                .en    (E),
                .din   (I[n]),
                .dout  (O[n]),
                .rise  (RISE[n]),
                .fall  (FALL[n])
            );
        end
    endgenerate
endmodule

// File: tb/tb_i_fab_filter.sv
// Bench for i_fab_filter: one instance per capture mode sharing clock, reset and enable.

module tb_i_fab_filter;
    logic C = 1'b0;
    logic R = 1'b0;
    logic E = 1'b1;

    logic [7:0] ib, ob, rb, fb;
    logic [3:0] is4, os4, rs4, fs4;
    logic [1:0] if4, of4, rf4, ff4;
    logic       i8, o8, r8, f8;
    logic [1:0] ir, o_r, rr, fr;

    i_fab_filter #(.WIDTH(8), .MODE("BYPASS")) u_byp (
        .C(C), .R(R), .E(E), .I(ib), .O(ob), .RISE(rb), .FALL(fb));
    i_fab_filter #(.WIDTH(4), .MODE("SYNC")) u_sync (
        .C(C), .R(R), .E(E), .I(is4), .O(os4), .RISE(rs4), .FALL(fs4));
    i_fab_filter #(.WIDTH(2), .MODE("FILTER"), .FILTER_CYCLES(4)) u_f4 (
        .C(C), .R(R), .E(E), .I(if4), .O(of4), .RISE(rf4), .FALL(ff4));
    i_fab_filter #(.WIDTH(1), .MODE("FILTER"), .FILTER_CYCLES(8)) u_f8 (
        .C(C), .R(R), .E(E), .I(i8), .O(o8), .RISE(r8), .FALL(f8));
    i_fab_filter #(.WIDTH(2), .MODE("REG"), .INIT_VALUE(2'b11)) u_reg (
        .C(C), .R(R), .E(E), .I(ir), .O(o_r), .RISE(rr), .FALL(fr));

    always #5 C = ~C;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge C);
        @(negedge C);
    endtask

    typedef struct {
        logic [3:0] i;
        logic [3:0] o;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;
    vec_t tv[6];

    typedef struct {
        logic [1:0] o;
        logic [1:0] rise;
        logic [1:0] fall;
    } exp_t;
    exp_t sbq[$];
    logic [1:0] mdl_o;

    task automatic reg_step(input logic [1:0] v);
        exp_t e;
        ir     = v;
        e.o    = v;
        e.rise = ~mdl_o & v;
        e.fall = mdl_o & ~v;
        mdl_o  = v;
        sbq.push_back(e);
        tick();
        e = sbq.pop_front();
        chk("reg_o", 64'(o_r), 64'(e.o));
        chk("reg_rise", 64'(rr), 64'(e.rise));
        chk("reg_fall", 64'(fr), 64'(e.fall));
    endtask

    initial begin
        ib = '0; is4 = '0; if4 = '0; i8 = 1'b0; ir = 2'b11;

        tv[0] = '{4'hA, 4'h0, 4'h0, 4'h0};
        tv[1] = '{4'hA, 4'hA, 4'hA, 4'h0};
        tv[2] = '{4'hA, 4'hA, 4'h0, 4'h0};
        tv[3] = '{4'h5, 4'hA, 4'h0, 4'h0};
        tv[4] = '{4'h5, 4'h5, 4'h5, 4'hA};
        tv[5] = '{4'h5, 4'h5, 4'h0, 4'h0};

        #12;
        chk("rst_sync_o", 64'(os4), 64'h0);
        chk("rst_sync_pulse", 64'({rs4, fs4}), 64'h0);
        chk("rst_f4_o", 64'(of4), 64'h0);
        chk("rst_f8_o", 64'(o8), 64'h0);
        chk("rst_reg_o", 64'(o_r), 64'h3);
        chk("rst_reg_pulse", 64'({rr, fr}), 64'h0);

        // bypass is combinational and ignores reset/clock
        for (int k = 0; k < 64; k++) begin
            ib = 8'($urandom);
            #1;
            chk("byp_o", 64'(ob), 64'(ib));
            chk("byp_pulse", 64'({rb, fb}), 64'h0);
        end

        @(negedge C);
        R = 1'b1;

        mdl_o = 2'b11;
        reg_step(2'b11);
        reg_step(2'b01);
        reg_step(2'b01);
        for (int k = 0; k < 20; k++) reg_step(2'($urandom));

        for (int k = 0; k < 6; k++) begin
            is4 = tv[k].i;
            tick();
            chk($sformatf("sync_o[%0d]", k), 64'(os4), 64'(tv[k].o));
            chk($sformatf("sync_rise[%0d]", k), 64'(rs4), 64'(tv[k].rise));
            chk($sformatf("sync_fall[%0d]", k), 64'(fs4), 64'(tv[k].fall));
        end

        // ch0 held high, ch1 a 3-cycle glitch
        for (int e = 1; e <= 8; e++) begin
            if4 = {1'(e <= 3), 1'b1};
            tick();
            chk($sformatf("f4_o@%0d", e), 64'(of4), 64'({1'b0, 1'(e >= 6)}));
            chk($sformatf("f4_rise@%0d", e), 64'(rf4), 64'({1'b0, 1'(e == 6)}));
            chk($sformatf("f4_fall@%0d", e), 64'(ff4), 64'h0);
        end
        for (int e = 1; e <= 6; e++) begin
            if4 = 2'b00;
            tick();
            chk($sformatf("f4_fo@%0d", e), 64'(of4), 64'({1'b0, 1'(e < 6)}));
            chk($sformatf("f4_ff@%0d", e), 64'(ff4), 64'({1'b0, 1'(e == 6)}));
        end

        // two disabled edges mid-count push the rise from edge 6 to edge 8
        for (int e = 1; e <= 10; e++) begin
            if4 = 2'b01;
            E = !(e == 4 || e == 5);
            tick();
            chk($sformatf("en_o@%0d", e), 64'(of4), 64'({1'b0, 1'(e >= 8)}));
            chk($sformatf("en_rise@%0d", e), 64'(rf4), 64'({1'b0, 1'(e == 8)}));
        end
        E = 1'b1;

        for (int e = 1; e <= 12; e++) begin
            i8 = 1'b1;
            tick();
            chk($sformatf("f8_o@%0d", e), 64'(o8), 64'(e >= 10));
            chk($sformatf("f8_rise@%0d", e), 64'(r8), 64'(e == 10));
        end
        i8 = 1'b0;
        ir = 2'b00;
        for (int e = 1; e <= 4; e++) tick();
        chk("pre_rst_f8_o", 64'(o8), 64'h1);
        chk("pre_rst_reg_o", 64'(o_r), 64'h0);

        @(posedge C);
        #2;
        R = 1'b0;
        #1;
        chk("arst_f8_o", 64'(o8), 64'h0);
        chk("arst_f8_pulse", 64'({r8, f8}), 64'h0);
        chk("arst_reg_o", 64'(o_r), 64'h3);
        chk("arst_reg_pulse", 64'({rr, fr}), 64'h0);
        chk("arst_f4_o", 64'(of4), 64'h0);

        @(negedge C);
        R = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            i8 = 1'b1;
            tick();
            chk($sformatf("rel_f8_o@%0d", e), 64'(o8), 64'(e >= 10));
            chk($sformatf("rel_f8_rise@%0d", e), 64'(r8), 64'(e == 10));
            chk($sformatf("rel_f8_fall@%0d", e), 64'(f8), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
